// File: rtl/synth_pkg.sv
// Shared sizing, command/voice payload types and output saturation for the voice engine.
package synth_pkg;

  localparam int unsigned NUM_VOICES = 256;
  localparam int unsigned PHASE_W    = 32;
  localparam int unsigned SAMPLE_W   = 24;
  localparam int unsigned VEL_W      = 7;
  localparam int unsigned IDX_W      = $clog2(NUM_VOICES);
  localparam int unsigned CMD_IDX_W  = 8;
  localparam int unsigned OUT_SHIFT  = 7;
  localparam int unsigned RAW_W      = 16;
  localparam int unsigned PROD_W     = RAW_W + VEL_W;
  localparam int unsigned ACC_W      = 32;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef struct packed {
    logic                 note_on;
    logic [CMD_IDX_W-1:0] idx;
    logic [PHASE_W-1:0]   tuning;
    logic [VEL_W-1:0]     velocity;
  } voice_cmd_t;

  typedef struct packed {
    logic               active;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] tuning;
    logic [VEL_W-1:0]   velocity;
  } voice_state_t;

  // Clamp a shifted sweep sum into the signed output sample range.
  function automatic logic [SAMPLE_W-1:0] saturate_sample(input logic signed [ACC_W-1:0] x);
    logic [SAMPLE_W-1:0] r;
    if (x > SAT_MAX) begin
      r = SAMPLE_W'(SAT_MAX);
    end else if (x < SAT_MIN) begin
      r = SAMPLE_W'(SAT_MIN);
    end else begin
      r = x[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_wave_gen.sv
// Sawtooth mapping of the phase MSBs and velocity scaling for one voice; purely combinational.
module voice_wave_gen
  import synth_pkg::*;
(
  input  logic [RAW_W-1:0]  phase_msb_i,
  input  logic [VEL_W-1:0]  velocity_i,
  input  logic              active_i,
  output logic [PROD_W-1:0] product_c_o
);

  logic        [RAW_W-1:0]  raw;
  logic signed [PROD_W-1:0] raw_ext;
  logic signed [PROD_W-1:0] vel_ext;
  logic signed [PROD_W-1:0] prod;

  // Inverting the MSB turns the unsigned ramp into a signed sawtooth starting at full negative.
  always_comb begin
    raw         = {~phase_msb_i[RAW_W-1], phase_msb_i[RAW_W-2:0]};
    raw_ext     = PROD_W'($signed(raw));
    vel_ext     = PROD_W'({1'b0, velocity_i});
    prod        = raw_ext * vel_ext;
    product_c_o = active_i ? prod : '0;
  end

endmodule

// File: rtl/voice_controller.sv
// Time-multiplexed DDS voice engine: per-voice storage, 3-stage sweep pipeline and mixer.
module voice_controller
  import synth_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_SPI_note_status,
  input  logic [CMD_IDX_W-1:0] i_SPI_voice_index,
  input  logic [PHASE_W-1:0]   i_SPI_tuning_code,
  input  logic [VEL_W-1:0]     i_SPI_velocity,
  input  logic                 i_SPI_flag,
  output logic [SAMPLE_W-1:0]  o_mixed_sample
);

  voice_cmd_t        cmd;
  logic              cmd_hit;
  logic [IDX_W-1:0]  cmd_idx;

  logic [NUM_VOICES-1:0] active_q;
  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]    tune_q  [NUM_VOICES];
  logic [VEL_W-1:0]      vel_q   [NUM_VOICES];

  logic [IDX_W-1:0] voice_q, voice_d;

  voice_state_t     s1_q, s1_d;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_valid_q;
  logic             fwd;
  logic             wb_en;
  logic [PHASE_W-1:0] wb_phase;

  logic [RAW_W-1:0] s2_phase_q;
  logic [VEL_W-1:0] s2_vel_q;
  logic             s2_act_q;
  logic             s2_valid_q;
  logic             s2_first_q;
  logic             s2_last_q;

  logic [PROD_W-1:0]       product;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic [SAMPLE_W-1:0]     mixed_q;

  // Command decode; out-of-range slots are dropped.
  always_comb begin
    cmd          = '0;
    cmd.note_on  = i_SPI_note_status;
    cmd.idx      = i_SPI_voice_index;
    cmd.tuning   = i_SPI_tuning_code;
    cmd.velocity = i_SPI_velocity;
    cmd_hit      = i_SPI_flag && (32'(i_SPI_voice_index) < NUM_VOICES);
    cmd_idx      = IDX_W'(cmd.idx);
  end

  // Stage-1 read with forwarding of a command that targets the voice being read this cycle.
  always_comb begin
    voice_d     = voice_q + IDX_W'(1);
    fwd         = cmd_hit && (cmd_idx == voice_q);
    s1_d        = '0;
    s1_d.active = fwd ? cmd.note_on : active_q[voice_q];
    if (fwd && cmd.note_on) begin
      s1_d.phase    = '0;
      s1_d.tuning   = cmd.tuning;
      s1_d.velocity = cmd.velocity;
    end else begin
      s1_d.phase    = phase_q[voice_q];
      s1_d.tuning   = tune_q[voice_q];
      s1_d.velocity = vel_q[voice_q];
    end
  end

  // A command to the voice being written back wins over the sweep's phase advance.
  always_comb begin
    wb_phase = s1_q.phase + s1_q.tuning;
    wb_en    = s1_valid_q && s1_q.active && !(cmd_hit && (cmd_idx == s1_idx_q));
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      active_q <= '0;
    end else if (cmd_hit) begin
      active_q[cmd_idx] <= cmd.note_on;
    end
  end

  // Voice parameter storage is intentionally not reset; inactive slots are don't-care.
  always_ff @(posedge i_clk) begin
    if (wb_en) begin
      phase_q[s1_idx_q] <= wb_phase;
    end
    if (cmd_hit && cmd.note_on) begin
      phase_q[cmd_idx] <= '0;
      tune_q[cmd_idx]  <= cmd.tuning;
      vel_q[cmd_idx]   <= cmd.velocity;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      voice_q    <= '0;
      s1_q       <= '0;
      s1_idx_q   <= '0;
      s1_valid_q <= 1'b0;
      s2_phase_q <= '0;
      s2_vel_q   <= '0;
      s2_act_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      voice_q    <= voice_d;
      s1_q       <= s1_d;
      s1_idx_q   <= voice_q;
      s1_valid_q <= 1'b1;
      s2_phase_q <= s1_q.phase[PHASE_W-1 -: RAW_W];
      s2_vel_q   <= s1_q.velocity;
      s2_act_q   <= s1_q.active;
      s2_valid_q <= s1_valid_q;
      s2_first_q <= (s1_idx_q == '0);
      s2_last_q  <= (s1_idx_q == IDX_W'(NUM_VOICES - 1));
    end
  end

  voice_wave_gen u_wave_gen (
    .phase_msb_i (s2_phase_q),
    .velocity_i  (s2_vel_q),
    .active_i    (s2_act_q),
    .product_c_o (product)
  );

  // Voice 0 starts a fresh sum, so sweeps run back to back without a clear cycle.
  always_comb begin
    sum     = (s2_first_q ? ACC_W'(0) : acc_q) + ACC_W'($signed(product));
    shifted = sum >>> OUT_SHIFT;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      acc_q   <= '0;
      mixed_q <= '0;
    end else if (s2_valid_q) begin
      acc_q <= sum;
      if (s2_last_q) begin
        mixed_q <= saturate_sample(shifted);
      end
    end
  end

  assign o_mixed_sample = mixed_q;

endmodule

// File: tb/tb_voice_controller.sv
// Directed bench for voice_controller: sweep-aligned note commands checked against hand-computed mixes.
module tb_voice_controller;

  localparam int SWEEP      = 256;
  localparam int SAMPLE_OFS = 386;  // mid-sweep point after sweep 0's output update (edge 258)

  logic        i_clk;
  logic        i_reset;
  logic        i_SPI_note_status;
  logic [7:0]  i_SPI_voice_index;
  logic [31:0] i_SPI_tuning_code;
  logic [6:0]  i_SPI_velocity;
  logic        i_SPI_flag;
  logic [23:0] o_mixed_sample;

  int total;
  int bad;
  int cyc;

  voice_controller dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_SPI_note_status (i_SPI_note_status),
    .i_SPI_voice_index (i_SPI_voice_index),
    .i_SPI_tuning_code (i_SPI_tuning_code),
    .i_SPI_velocity    (i_SPI_velocity),
    .i_SPI_flag        (i_SPI_flag),
    .o_mixed_sample    (o_mixed_sample)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Edge count since the last reset release; edge 1 is the first rising edge out of reset.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [23:0] got, input logic signed [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge i_clk);
  endtask

  // Present a command so that it is sampled on rising edge edge_n (and held for hold edges).
  task automatic send_cmd(input int edge_n, input bit on, input int idx, input logic [31:0] tun,
                          input int vel, input int hold);
    wait_cyc(edge_n - 1);
    i_SPI_note_status = on;
    i_SPI_voice_index = 8'(idx);
    i_SPI_tuning_code = tun;
    i_SPI_velocity    = 7'(vel);
    i_SPI_flag        = 1'b1;
    repeat (hold) @(negedge i_clk);
    i_SPI_flag        = 1'b0;
  endtask

  task automatic sample(input int m, input string tag, input logic signed [23:0] exp);
    wait_cyc(SAMPLE_OFS + SWEEP * m);
    chk(tag, o_mixed_sample, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    i_reset           = 1'b0;
    i_SPI_note_status = 1'b0;
    i_SPI_voice_index = '0;
    i_SPI_tuning_code = '0;
    i_SPI_velocity    = '0;
    i_SPI_flag        = 1'b0;

    repeat (5) @(negedge i_clk);
    chk("reset", o_mixed_sample, 24'sd0);
    i_reset = 1'b1;

    sample(0, "idle0", 0);
    sample(1, "idle1", 0);

    send_cmd(SWEEP * 2 + 200, 1'b1, 253, 32'h0100_0000, 127, 1);
    send_cmd(SWEEP * 2 + 201, 1'b1, 252, 32'h0100_0000, 127, 1);
    sample(2, "joint_first", -65024);
    sample(3, "joint_second", -64516);
    sample(4, "joint_third", -64008);

    send_cmd(SWEEP * 5 + 200, 1'b0, 253, 32'h0, 0, 1);
    sample(5, "off253", -31750);

    sample(129, "saw_127", -254);
    sample(130, "saw_mid", 0);
    sample(257, "saw_255", 32258);
    sample(258, "saw_period", -32512);

    send_cmd(SWEEP * 260 + 200, 1'b0, 252, 32'h0, 0, 3);
    sample(260, "all_off", 0);

    send_cmd(SWEEP * 261 + 200, 1'b1, 7, 32'd12345, 0, 1);
    sample(262, "vel0", 0);

    send_cmd(SWEEP * 263 + 200, 1'b1, 220, 32'h0100_0000, 127, 1);
    sample(263, "v220_first", -32512);
    // Retune lands on the edge where voice 220's sweep writeback happens.
    send_cmd(SWEEP * 264 + 222, 1'b1, 220, 32'h0200_0000, 127, 1);
    sample(264, "coll_inflight", -32258);
    sample(265, "coll_phase0", -32512);
    sample(266, "coll_retune", -32004);

    wait_cyc(SWEEP * 267 + 60);
    i_reset = 1'b0;
    #1;
    chk("rst_mid", o_mixed_sample, 24'sd0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    sample(0, "post_rst0", 0);
    sample(1, "post_rst1", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
